// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// Holds FSM state, owner encoding and the registered port request.
package core;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;
    localparam int ARB_BW = ARB_DW / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    typedef struct packed {
        logic              we;
        logic [ARB_BW-1:0] be;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } mem_port_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts MEM wins while IF waits; forces an IF win at the limit.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb,
    input  logic if_req,
    input  logic if_win,
    output logic force_if
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (arb) begin
            if (if_win || !if_req) begin
                cnt_q <= '0;
            end else if (cnt_q != W'(LIMIT)) begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

    assign force_if = if_req && (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one txn at a time.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import core::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    output logic                    dm_gnt_o,
    output logic                    dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o
);

    localparam int BE_W = DATA_WIDTH / 8;

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;
    logic          drop_q, drop_d;
    mem_port_req_t req_q, req_d;

    logic own_if;
    logic flush_hit;
    logic arb_en;
    logic if_wins;
    logic force_if;
    logic mask_if;

    assign own_if    = (owner_q == OWN_IF);
    assign flush_hit = if_flush_i && own_if && (state_q != ARB_IDLE);
    assign arb_en    = (if_req_i || dm_req_i) &&
                       ((state_q == ARB_IDLE) ||
                        ((state_q == ARB_WAIT) && mem_rvalid_i));
    assign if_wins   = force_if || !dm_req_i;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .arb      (arb_en),
        .if_req   (if_req_i),
        .if_win   (if_wins),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0 && (STARVE_LIMIT != 0);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        req_d   = req_q;
        if (flush_hit) drop_d = 1'b1;
        unique case (state_q)
            ARB_IDLE: drop_d = 1'b0;
            ARB_REQ: begin
                if (mem_gnt_i) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // A finishing response and a new winner share the same cycle
        if (arb_en) begin
            state_d = ARB_REQ;
            drop_d  = 1'b0;
            if (if_wins) begin
                owner_d = OWN_IF;
                req_d   = '{we:    1'b0,
                            be:    '1,
                            addr:  ARB_AW'(if_addr_i),
                            wdata: '0};
            end else begin
                owner_d = OWN_DM;
                req_d   = '{we:    dm_we_i,
                            be:    ARB_BW'(dm_be_i),
                            addr:  ARB_AW'(dm_addr_i),
                            wdata: ARB_DW'(dm_wdata_i)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            drop_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
        end
    end

    // Same-cycle flush already counts as dropped
    assign mask_if = drop_q || if_flush_i;

    assign mem_req_o   = (state_q == ARB_REQ);
    assign mem_we_o    = req_q.we;
    assign mem_be_o    = BE_W'(req_q.be);
    assign mem_addr_o  = ADDR_WIDTH'(req_q.addr);
    assign mem_wdata_o = DATA_WIDTH'(req_q.wdata);

    assign if_gnt_o    = mem_gnt_i && (state_q == ARB_REQ) &&
                         own_if && !mask_if;
    assign dm_gnt_o    = mem_gnt_i && (state_q == ARB_REQ) && !own_if;
    assign if_rvalid_o = mem_rvalid_i && (state_q == ARB_WAIT) &&
                         own_if && !mask_if;
    assign dm_rvalid_o = mem_rvalid_i && (state_q == ARB_WAIT) && !own_if;
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;

    assign busy_o = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model.
// Build with ARB_STARVE_GUARD_EN to cover the starvation guard.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_cmp;
    int n_fail;

    mem_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_flush_i   (if_flush_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .dm_req_i     (dm_req_i),
        .dm_we_i      (dm_we_i),
        .dm_be_i      (dm_be_i),
        .dm_addr_i    (dm_addr_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_gnt_o     (dm_gnt_o),
        .dm_rvalid_o  (dm_rvalid_o),
        .dm_rdata_o   (dm_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grant gated by gnt_en, response gated by rsp_en
    logic        gnt_en;
    logic        rsp_en;
    logic        pend;
    logic [31:0] rdata_r;
    logic [31:0] mem [0:1023];
    logic [9:0]  idx;

    assign idx          = mem_addr_o[11:2];
    assign mem_gnt_i    = mem_req_o && gnt_en;
    assign mem_rvalid_i = pend && rsp_en;
    assign mem_rdata_i  = rdata_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            rdata_r  <= 32'h0;
            mem[4]   <= 32'h00500093;
            mem[8]   <= 32'h33334444;
            mem[12]  <= 32'h77778888;
            mem[16]  <= 32'hAAAAAAAA;
            mem[32]  <= 32'h55556666;
            mem[256] <= 32'h11112222;
        end else begin
            if (mem_rvalid_i) pend <= 1'b0;
            if (mem_req_o && mem_gnt_i) begin
                pend <= 1'b1;
                if (mem_we_o) begin
                    rdata_r <= 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be_o[b])
                            mem[idx][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                    end
                end else begin
                    rdata_r <= mem[idx];
                end
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   32'(busy_o),      32'h0);
        chk({tag, "_mreq"},   32'(mem_req_o),   32'h0);
        chk({tag, "_mwe"},    32'(mem_we_o),    32'h0);
        chk({tag, "_mbe"},    32'(mem_be_o),    32'h0);
        chk({tag, "_maddr"},  mem_addr_o,       32'h0);
        chk({tag, "_mwdata"}, mem_wdata_o,      32'h0);
        chk({tag, "_ignt"},   32'(if_gnt_o),    32'h0);
        chk({tag, "_irv"},    32'(if_rvalid_o), 32'h0);
        chk({tag, "_irdata"}, if_rdata_o,       32'h0);
        chk({tag, "_dgnt"},   32'(dm_gnt_o),    32'h0);
        chk({tag, "_drv"},    32'(dm_rvalid_o), 32'h0);
        chk({tag, "_drdata"}, dm_rdata_o,       32'h0);
    endtask

    int dm_gnts;
    int if_gnt_at;

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        if_req_i   = 1'b0;
        if_addr_i  = 32'h0;
        if_flush_i = 1'b0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_be_i    = 4'h0;
        dm_addr_i  = 32'h0;
        dm_wdata_i = 32'h0;
        gnt_en     = 1'b1;
        rsp_en     = 1'b1;

        // reset state
        @(negedge clk); #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // IF-only fetch of 0x10
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        #1;
        chk("f1_pre_busy", 32'(busy_o), 32'h0);
        @(negedge clk); #1;
        chk("f1_mreq",  32'(mem_req_o),  32'h1);
        chk("f1_maddr", mem_addr_o,      32'h10);
        chk("f1_mwe",   32'(mem_we_o),   32'h0);
        chk("f1_ignt",  32'(if_gnt_o),   32'h1);
        chk("f1_dgnt",  32'(dm_gnt_o),   32'h0);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        chk("f1_irv",   32'(if_rvalid_o), 32'h1);
        chk("f1_irdat", if_rdata_o,       32'h00500093);
        chk("f1_drv",   32'(dm_rvalid_o), 32'h0);
        chk("f1_mreq2", 32'(mem_req_o),   32'h0);
        @(negedge clk); #1;
        chk("f1_idle",  32'(busy_o), 32'h0);

        // simultaneous IF 0x20 and MEM load 0x400
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_be_i   = 4'hF;
        dm_addr_i = 32'h400;
        @(negedge clk); #1;
        chk("s_maddr1", mem_addr_o,     32'h400);
        chk("s_dgnt",   32'(dm_gnt_o),  32'h1);
        chk("s_ignt0",  32'(if_gnt_o),  32'h0);
        dm_req_i = 1'b0;
        @(negedge clk); #1;
        chk("s_drv",    32'(dm_rvalid_o), 32'h1);
        chk("s_drdat",  dm_rdata_o,       32'h11112222);
        chk("s_irv0",   32'(if_rvalid_o), 32'h0);
        @(negedge clk); #1;
        chk("s_maddr2", mem_addr_o,     32'h20);
        chk("s_ignt",   32'(if_gnt_o),  32'h1);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        chk("s_irv",    32'(if_rvalid_o), 32'h1);
        chk("s_irdat",  if_rdata_o,       32'h33334444);

        // store with 3 stalled grant cycles
        @(negedge clk);
        gnt_en     = 1'b0;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_be_i    = 4'b0011;
        dm_addr_i  = 32'h40;
        dm_wdata_i = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) gnt_en = 1'b1;
            #1;
            chk("st_mreq",  32'(mem_req_o), 32'h1);
            chk("st_mwe",   32'(mem_we_o),  32'h1);
            chk("st_mbe",   32'(mem_be_o),  32'h3);
            chk("st_maddr", mem_addr_o,     32'h40);
            chk("st_mwdat", mem_wdata_o,    32'hDEADBEEF);
            chk("st_dgnt",  32'(dm_gnt_o),  (i == 3) ? 32'h1 : 32'h0);
        end
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
        @(negedge clk); #1;
        chk("st_drv",  32'(dm_rvalid_o), 32'h1);
        chk("st_irv",  32'(if_rvalid_o), 32'h0);
        @(negedge clk);
        dm_req_i  = 1'b1;
        dm_be_i   = 4'hF;
        dm_addr_i = 32'h40;
        @(negedge clk); #1;
        chk("ld_dgnt", 32'(dm_gnt_o), 32'h1);
        dm_req_i = 1'b0;
        @(negedge clk); #1;
        chk("ld_drv",  32'(dm_rvalid_o), 32'h1);
        chk("ld_rdat", dm_rdata_o,       32'hAAAABEEF);

        // flush during WAIT_RSP of fetch 0x30
        @(negedge clk);
        rsp_en    = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h30;
        @(negedge clk); #1;
        chk("fl_ignt", 32'(if_gnt_o), 32'h1);
        if_req_i = 1'b0;
        @(negedge clk);
        if_flush_i = 1'b1;
        #1;
        chk("fl_busy", 32'(busy_o),      32'h1);
        chk("fl_irv0", 32'(if_rvalid_o), 32'h0);
        @(negedge clk);
        if_flush_i = 1'b0;
        rsp_en     = 1'b1;
        #1;
        chk("fl_mrv",  32'(mem_rvalid_i), 32'h1);
        chk("fl_irv1", 32'(if_rvalid_o),  32'h0);
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h80;
        #1;
        chk("fl_idle", 32'(busy_o), 32'h0);
        @(negedge clk); #1;
        chk("fl_ignt2", 32'(if_gnt_o), 32'h1);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        chk("fl_irv2",  32'(if_rvalid_o), 32'h1);
        chk("fl_irdat", if_rdata_o,       32'h55556666);

        // starvation: MEM requests continuously while IF waits
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_be_i   = 4'hF;
        dm_addr_i = 32'h400;
        dm_gnts   = 0;
        if_gnt_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); #1;
            if (dm_gnt_o) dm_gnts++;
            if (if_gnt_o) begin
                if_gnt_at = i;
                break;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("sv_dm_gnts", 32'(dm_gnts),   32'd4);
        chk("sv_if_at",   32'(if_gnt_at), 32'd9);
`else
        chk("sv_dm_gnts", 32'(dm_gnts),   32'd6);
        chk("sv_if_at",   32'(if_gnt_at), 32'd0);
`endif
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("sv_idle", 32'(busy_o), 32'h0);

        // reset asserted during WAIT_RSP
        @(negedge clk);
        rsp_en    = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        @(negedge clk); #1;
        chk("rs_ignt", 32'(if_gnt_o), 32'h1);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        chk("rs_busy", 32'(busy_o), 32'h1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rs");
        @(negedge clk);
        rst    = 1'b0;
        rsp_en = 1'b1;
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h80;
        @(negedge clk); #1;
        chk("rs_ignt2", 32'(if_gnt_o),  32'h1);
        chk("rs_maddr", mem_addr_o,     32'h80);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        chk("rs_irv",   32'(if_rvalid_o), 32'h1);
        chk("rs_irdat", if_rdata_o,       32'h55556666);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
